// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the core data port and data memory.
// Stores are captured in the same cycle they are issued. They drain in order
// over a valid/ready handshake.
// Optional feature macro: STORE_BUF_FWD_EN. When it is defined, loads are
// forwarded from the youngest matching buffered store. When it is not defined,
// a load stalls until the buffer is empty.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       MemWrite,
  input  logic [31:0]                ALUResult,
  input  logic [31:0]                WriteData,
  input  logic                       ld_req,
  output logic                       stall,
  output logic                       mem_valid,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       fwd_hit,
  output logic [31:0]                fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   addr_mem_r [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic          full_s;
  logic          empty_s;
  logic          stall_s;
  logic          push_s;
  logic          pop_s;

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});

  // Accept a store only when it is not stalled.
  // Retire the head entry whenever memory takes it.
  assign push_s  = MemWrite && !stall_s;
  assign pop_s   = !empty_s && mem_ready;

  // Stall decision.
  // A store stalls only on a full buffer. A full buffer never passes a store
  // through, even when the head retires in the same cycle.
  // A load issued together with a store is ignored.
  // Without forwarding, a load waits for the buffer to drain.
  always_comb begin
    stall_s = 1'b0;
    if (MemWrite) begin
      stall_s = full_s;
    end else begin
`ifdef STORE_BUF_FWD_EN
      stall_s = 1'b0;
`else
      stall_s = ld_req && !empty_s;
`endif
    end
  end

  // Head and tail pointers. They wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r <= {PW{1'b0}};
      tail_r <= {PW{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        head_r <= head_r + {{(PW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Occupancy counter. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  // Reset clears it so the memory-side outputs read zero after reset.
  // The address is kept verbatim, including its byte offset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= 32'd0;
        data_mem_r[i] <= 32'd0;
      end
    end else begin
      if (push_s) begin
        addr_mem_r[tail_r] <= ALUResult;
        data_mem_r[tail_r] <= WriteData;
      end
    end
  end

  // The memory side is driven only from the count and the storage registers.
  // There is no path from the core inputs.
  assign mem_valid = !empty_s;
  assign mem_addr  = addr_mem_r[head_r];
  assign mem_wdata = data_mem_r[head_r];
  assign count     = count_r;
  assign empty     = empty_s;
  assign stall     = stall_s;

`ifdef STORE_BUF_FWD_EN
  logic          fwd_hit_s;
  logic [31:0]   fwd_data_s;
  logic [PW-1:0] idx_s;

  // Whole-word match search, walking from the oldest entry to the youngest.
  // A later match overwrites an earlier one, so the youngest matching store wins.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = 32'd0;
    idx_s      = head_r;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head_r + PW'(i);
      if ((CW'(i) < count_r) &&
          (addr_mem_r[idx_s][31:2] == ALUResult[31:2])) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = data_mem_r[idx_s];
      end else begin
        fwd_hit_s  = fwd_hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
    if (!(ld_req && !MemWrite)) begin
      fwd_hit_s  = 1'b0;
      fwd_data_s = 32'd0;
    end else begin
      fwd_hit_s  = fwd_hit_s;
      fwd_data_s = fwd_data_s;
    end
  end

  assign fwd_hit  = fwd_hit_s;
  assign fwd_data = fwd_data_s;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = 32'd0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed test of store_buffer.
// A queue model of the buffer contents is checked every cycle. A set of
// hand-computed literal expectations is also checked.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          MemWrite = 1'b0;
  logic [31:0]   ALUResult = 32'd0;
  logic [31:0]   WriteData = 32'd0;
  logic          ld_req = 1'b0;
  logic          mem_ready = 1'b0;
  logic          stall;
  logic          mem_valid;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [CW-1:0] count;
  logic          empty;
  logic          fwd_hit;
  logic [31:0]   fwd_data;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit chk_en   = 1'b0;

  // Model of the buffer contents: {addr, data}, with the oldest entry at index 0.
  logic [63:0] q[$];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .ld_req(ld_req), .stall(stall),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .count(count), .empty(empty),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Stall as the rules define it, computed from the model occupancy.
  function automatic logic m_stall();
    logic s;
    s = 1'b0;
    if (MemWrite) s = (q.size() == DEPTH);
`ifndef STORE_BUF_FWD_EN
    else s = ld_req && (q.size() != 0);
`endif
    return s;
  endfunction

  // Forwarding result: {hit, data} from the youngest word-address match.
  function automatic logic [32:0] m_fwd();
    logic [32:0] r;
    r = 33'd0;
`ifdef STORE_BUF_FWD_EN
    if (ld_req && !MemWrite) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i][63:34] == ALUResult[31:2]) begin
          r = {1'b1, q[i][31:0]};
          break;
        end
      end
    end
`endif
    return r;
  endfunction

  // Model update on the same edges as the design.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
    end else begin
      logic do_push, do_pop;
      do_push = MemWrite && !m_stall();
      do_pop  = (q.size() != 0) && mem_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({ALUResult, WriteData});
    end
  end

  // Compare process: every output against the model, in the low clock phase.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [32:0] f;
      f = m_fwd();
      chk("stall", 32'(stall), 32'(m_stall()));
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
      chk("fwd_hit", 32'(fwd_hit), 32'(f[32]));
      chk("fwd_data", fwd_data, f[31:0]);
      if (q.size() != 0) begin
        chk("mem_addr", mem_addr, q[0][63:32]);
        chk("mem_wdata", mem_wdata, q[0][31:0]);
      end
    end
  end

  // Apply one cycle of inputs just after the rising edge.
  // Return at the following falling edge.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                      input logic ld, input logic rdy);
    @(posedge clk);
    #1;
    MemWrite  = mw;
    ALUResult = a;
    WriteData = wd;
    ld_req    = ld;
    mem_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    chk_en = 1'b1;
    // Reset state
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    #12 rst = 1'b1;

    // Single store, retired immediately
    step(1'b1, 32'd100, 32'd25, 1'b0, 1'b1);
    chk("t1_stall", 32'(stall), 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("t1_valid", 32'(mem_valid), 32'd1);
    chk("t1_addr", mem_addr, 32'd100);
    chk("t1_wdata", mem_wdata, 32'd25);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("t1_empty", 32'(empty), 32'd1);

    // Fill and overflow
    for (int i = 0; i < 4; i++) step(1'b1, 32'(96 + 4 * i), 32'(i + 1), 1'b0, 1'b0);
    step(1'b1, 32'd112, 32'd5, 1'b0, 1'b0);
    chk("t2_full_stall", 32'(stall), 32'd1);
    chk("t2_full_count", 32'(count), 32'd4);
    chk("t2_head", mem_addr, 32'd96);
    step(1'b1, 32'd112, 32'd5, 1'b0, 1'b1);
    chk("t2_pop_stall", 32'(stall), 32'd1);
    chk("t2_pop_count", 32'(count), 32'd4);
    step(1'b1, 32'd112, 32'd5, 1'b0, 1'b0);
    chk("t2_retry_stall", 32'(stall), 32'd0);
    chk("t2_retry_count", 32'(count), 32'd3);
    chk("t2_retry_head", mem_addr, 32'd100);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("t2_drained", 32'(count), 32'd0);

    // Backpressure ordering with pointer wrap
    for (int i = 0; i < 6; i++) step(1'b1, 32'(200 + 4 * i), 32'(50 + i), 1'b0, (i % 2) == 0);
    for (int i = 0; i < 12; i++) step(1'b0, 32'd0, 32'd0, 1'b0, (i % 2) == 0);
    chk("t3_drained", 32'(count), 32'd0);

`ifdef STORE_BUF_FWD_EN
    // Forwarding of the youngest matching store
    step(1'b1, 32'h64, 32'd7, 1'b0, 1'b0);
    step(1'b1, 32'h64, 32'd9, 1'b0, 1'b0);
    step(1'b0, 32'h66, 32'd0, 1'b1, 1'b0);
    chk("t4_hit", 32'(fwd_hit), 32'd1);
    chk("t4_data", fwd_data, 32'd9);
    chk("t4_stall", 32'(stall), 32'd0);
    step(1'b0, 32'h68, 32'd0, 1'b1, 1'b0);
    chk("t4_miss_hit", 32'(fwd_hit), 32'd0);
    chk("t4_miss_data", fwd_data, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
`else
    // Load drains the buffer before it proceeds
    step(1'b1, 32'h80, 32'h11, 1'b0, 1'b0);
    step(1'b0, 32'h80, 32'd0, 1'b1, 1'b0);
    chk("t4_ld_stall", 32'(stall), 32'd1);
    chk("t4_ld_hit", 32'(fwd_hit), 32'd0);
    step(1'b0, 32'h80, 32'd0, 1'b1, 1'b0);
    chk("t4_ld_stall2", 32'(stall), 32'd1);
    step(1'b0, 32'h80, 32'd0, 1'b1, 1'b1);
    chk("t4_ld_stall3", 32'(stall), 32'd1);
    step(1'b0, 32'h80, 32'd0, 1'b1, 1'b0);
    chk("t4_ld_go", 32'(stall), 32'd0);
    chk("t4_ld_count", 32'(count), 32'd0);
    step(1'b1, 32'h84, 32'd5, 1'b1, 1'b0);
    chk("t4_st_ld_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 2; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
`endif

    // Asynchronous reset in the middle of a handshake
    for (int i = 0; i < 3; i++) step(1'b1, 32'(16 + 4 * i), 32'(i + 70), 1'b0, 1'b0);
    step(1'b0, 32'h10, 32'd0, 1'b1, 1'b0);
    chk("t5_pre_count", 32'(count), 32'd3);
    chk("t5_pre_valid", 32'(mem_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_valid", 32'(mem_valid), 32'd0);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_stall", 32'(stall), 32'd0);
    chk("t5_fwd_hit", 32'(fwd_hit), 32'd0);
    chk("t5_addr", mem_addr, 32'd0);
    ld_req = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    step(1'b1, 32'h300, 32'h33, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t5_new_addr", mem_addr, 32'h300);
    chk("t5_new_wdata", mem_wdata, 32'h33);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t5_final_empty", 32'(empty), 32'd1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle core's data-memory port and the data memory. Captures each store (MemWrite, ALUResult as address, WriteData) in a small in-order FIFO, returns control to the core in the same cycle, and drains entries to memory over a valid/ready handshake. Stalls the core only when the buffer cannot accept a store, or when a load cannot safely bypass pending stores.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- MemWrite  in  1  store strobe from core.
- ALUResult  in  32  store/load byte address from core.
- WriteData  in  32  store data from core.
- ld_req  in  1  core is executing a load this cycle, address on ALUResult.
- stall  out  1  core must hold its PC and retry the current instruction.
- mem_valid  out  1  head entry is presented to memory.
- mem_addr  out  32  head entry address.
- mem_wdata  out  32  head entry data.
- mem_ready  in  1  memory accepts head entry this cycle.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- empty  out  1  count == 0.
- fwd_hit  out  1  load address matches a buffered store.
- fwd_data  out  32  data of youngest matching store.

## Operation
- Storage: DEPTH entries of {addr[31:0], data[31:0]}; head/tail pointers of $clog2(DEPTH) bits, wrap modulo DEPTH; count tracks occupancy.
- full = (count == DEPTH); empty = (count == 0).
- Push: MemWrite && !stall writes {ALUResult, WriteData} at tail, tail+1.
- Pop: mem_valid && mem_ready, head+1.
- mem_valid = !empty; mem_addr/mem_wdata driven straight from the head entry (storage output, no combinational path from core inputs).
- stall = (MemWrite && full) || load-hazard term (see Configuration). Combinational.
- Full with simultaneous pop and push: push rejected, stall = 1 (no pass-through); the core retries next cycle and succeeds.
- Empty with push: the store is not forwarded to memory in the same cycle; mem_valid rises next cycle.
- Push and pop in the same cycle at 0 < count < DEPTH: count unchanged, both pointers advance.
- Address stored verbatim, including bits [1:0]; the block imposes no alignment.
- MemWrite && ld_req together is illegal from the core. Behaviour in that case: the store is handled normally and ld_req is ignored.

## Timing
- Reset (rst = 0, asynchronous): head = tail = 0, count = 0, empty = 1, mem_valid = 0, stall = 0, fwd_hit = 0, fwd_data = 0. mem_addr and mem_wdata = 0; storage is cleared on reset. Pending entries are discarded, including in the middle of a handshake; mem_valid falls without waiting for a clock edge.
- Store-to-memory latency: minimum 1 cycle (push at edge N, mem_valid at N+1, retire at the first edge with mem_ready = 1).
- mem_addr/mem_wdata stay stable while mem_valid = 1 and mem_ready = 0.
- stall, fwd_hit, fwd_data are same-cycle combinational functions of the inputs and current state.
- Throughput: one push and one pop per cycle.

## Configuration
- STORE_BUF_FWD_EN defined:
  - Load forwarding is enabled.
  - fwd_hit = ld_req && some occupied entry has addr[31:2] == ALUResult[31:2].
  - fwd_data is the data of the youngest such entry, searching from tail-1 toward head. When fwd_hit = 0, fwd_data = 0.
  - Loads never stall; the core muxes fwd_data over the memory read data when fwd_hit = 1.
  - Whole-word match only.
- STORE_BUF_FWD_EN undefined:
  - No comparators.
  - fwd_hit and fwd_data are tied to 0.
  - stall additionally asserts when ld_req && !empty, so the buffer drains before any load proceeds.

## Test plan
- Reset then single store: rst low 22 ns, then MemWrite with ALUResult = 100, WriteData = 25 and mem_ready = 1 -> stall = 0; next cycle mem_valid = 1, mem_addr = 100, mem_wdata = 25; empty = 1 one cycle later.
- Fill/overflow, DEPTH = 4, mem_ready = 0: stores to addresses 96, 100, 104, 108 -> count = 4. Fifth store -> stall = 1, count stays 4. Raise mem_ready for one cycle -> 96 retires, stall stays 1 that cycle; the retried store is accepted the following cycle.
- Backpressure ordering: 6 stores with mem_ready toggling 1010… -> memory receives the addresses in issue order, each held stable while mem_ready = 0. Pointer wrap is exercised.
- Forwarding (macro on): store 0x64 ← 7, then store 0x64 ← 9, mem_ready = 0, then ld_req with ALUResult = 0x66 -> fwd_hit = 1, fwd_data = 9, stall = 0. ld_req with ALUResult = 0x68 -> fwd_hit = 0, fwd_data = 0.
- Load drain (macro off): one pending store, ld_req = 1 -> stall = 1 until the store retires, then stall = 0; fwd_hit = 0 throughout.
- Reset mid-handshake: 3 entries, mem_valid = 1, mem_ready = 0. Assert rst asynchronously mid-cycle -> mem_valid, count, stall and fwd_hit go to 0 immediately. After release, the first new store appears at mem_addr.
